dmem_responder: RTL and testbench

- Data-side memory responder for the pipelined MIPS core; it answers the core's M-stage data port (memwrite, address, write data, read data).
- Provides a word-addressed data RAM plus a small memory-mapped I/O window: a cycle counter, a console output FIFO with a valid/ready drain port, and a compare timer.
- Reads are combinational so the core's single-cycle memory-stage timing holds. Writes commit on the clock edge.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_console_fifo.sv | 51 +++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, status bit indices and the
// MMIO select bit.
package dmem_pkg;

  localparam int unsigned MmioSelBit = 31;

  localparam logic [7:0] OffCycle      = 8'h00;
  localparam logic [7:0] OffConsData   = 8'h04;
  localparam logic [7:0] OffConsStatus = 8'h08;
  localparam logic [7:0] OffTimerCmp   = 8'h0C;
  localparam logic [7:0] OffTimerStat  = 8'h10;

  localparam int unsigned StatFull  = 0;
  localparam int unsigned StatEmpty = 1;
  localparam int unsigned StatOvf   = 2;

  localparam int unsigned TimerExp = 0;

endpackage

// File: rtl/dmem_responder_console_fifo.sv
// Console output FIFO: storage, wrapping pointers, occupancy count and push/pop arbitration.
// A push while full is accepted only when a pop frees the head in the same cycle.
module console_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (rd_en) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus MMIO cycle counter, console FIFO and compare timer.
// Build option DMEM_TIMER_EN enables TIMER_CMP/TIMER_STAT and timer_irq.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_AW     = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              cons_valid,
  output logic [FIFO_W-1:0] cons_data,
  input  logic              cons_ready,
  output logic              timer_irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_sel;
  logic [7:0]        off;
  logic [31:0]       cycle_q;
  logic              ovf_q;
  logic [31:0]       timer_cmp_q;
  logic              timer_exp_q;
  logic              push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [31:0]       cons_status;
  logic              unused_addr;

  assign mmio_sel    = addr[MmioSelBit];
  assign off         = addr[7:0];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign unused_addr = ^{addr[30:8], addr[1:0]};

  assign push       = memwrite && mmio_sel && (off == OffConsData);
  assign cons_valid = !fifo_empty;
  assign pop        = cons_valid && cons_ready;

  console_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (writedata[FIFO_W-1:0]),
    .rdata_o (cons_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    cons_status           = '0;
    cons_status[StatFull]  = fifo_full;
    cons_status[StatEmpty] = fifo_empty;
    cons_status[StatOvf]   = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (memwrite && !mmio_sel) ram_q[ram_idx] <= writedata;
  end

  // Overflow set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (push && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (memwrite && mmio_sel && (off == OffConsStatus) && writedata[StatOvf]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic timer_event;
  assign timer_event = (cycle_q == timer_cmp_q) && (timer_cmp_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_cmp_q <= '0;
      timer_exp_q <= 1'b0;
    end else begin
      if (memwrite && mmio_sel && (off == OffTimerCmp)) timer_cmp_q <= writedata;
      if (timer_event) begin
        timer_exp_q <= 1'b1;
      end else if (memwrite && mmio_sel && (off == OffTimerStat) && writedata[TimerExp]) begin
        timer_exp_q <= 1'b0;
      end
    end
  end
`else
  // Without the timer these registers read as unmapped zeros.
  assign timer_cmp_q = '0;
  assign timer_exp_q = 1'b0;
`endif

  assign timer_irq = timer_exp_q;

  always_comb begin
    readdata = '0;
    if (!mmio_sel) begin
      readdata = ram_q[ram_idx];
    end else begin
      case (off)
        OffCycle:      readdata = cycle_q;
        OffConsData:   readdata = 32'(fifo_count);
        OffConsStatus: readdata = cons_status;
        OffTimerCmp:   readdata = timer_cmp_q;
        OffTimerStat:  readdata = {31'b0, timer_exp_q};
        default:       readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; timer checks follow DMEM_TIMER_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ACycle  = 32'h8000_0000;
  localparam logic [31:0] ACons   = 32'h8000_0004;
  localparam logic [31:0] AStat   = 32'h8000_0008;
  localparam logic [31:0] ATmrCmp = 32'h8000_000C;
  localparam logic [31:0] ATmrSt  = 32'h8000_0010;

  dmem_responder #(
    .RAM_AW     (6),
    .FIFO_DEPTH (8),
    .FIFO_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .readdata   (readdata),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, readdata, exp);
  endtask

  logic [7:0] exp_q [9];
  logic       seen;

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0; cons_ready = 1'b0;

    // RAM write/read, offset ignore, aliasing, read-during-write, survives reset
    do_reset();
    check_eq("rst_valid", {31'b0, cons_valid}, 32'd0);
    check_eq("rst_irq", {31'b0, timer_irq}, 32'd0);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_off", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    memwrite = 1'b1; addr = 32'h0000_0010; writedata = 32'h1234_5678;
    #1;
    check_eq("ram_rdw_old", readdata, 32'hDEAD_BEEF);
    @(negedge clk);
    memwrite = 1'b0;
    rd("ram_new", 32'h0000_0010, 32'h1234_5678);
    do_reset();
    rd("ram_keep", 32'h0000_0010, 32'h1234_5678);

    // Cycle counter
    do_reset();
    rd("cyc0", ACycle, 32'd0);
    repeat (5) @(negedge clk);
    rd("cyc5", ACycle, 32'd5);
    rd("cyc5_hi_ign", 32'hFFFF_FF00, 32'd5);
    rd("unmapped", 32'h8000_0020, 32'd0);
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_q;
    addr = ACycle;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1;
      if (readdata == 32'hFFFF_FFFF) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("cyc_max_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    rd("cyc_wrap", ACycle, 32'd0);

    // FIFO fill with overflow, then drain
    do_reset();
    rd("fifo_rst_stat", AStat, 32'b010);
    for (int k = 0; k < 9; k++) wr(ACons, 32'h41 + k);
    rd("fifo_full_stat", AStat, 32'b101);
    rd("fifo_full_cnt", ACons, 32'd8);
    cons_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("drain_valid", {31'b0, cons_valid}, 32'd1);
      check_eq("drain_data", {24'b0, cons_data}, 32'h41 + k);
      @(negedge clk);
    end
    check_eq("drain_end_valid", {31'b0, cons_valid}, 32'd0);
    rd("empty_ovf_stat", AStat, 32'b110);
    cons_ready = 1'b0;
    wr(AStat, 32'h4);
    rd("ovf_clr_stat", AStat, 32'b010);

    // Push+pop while empty: only the push happens
    cons_ready = 1'b1;
    wr(ACons, 32'h77);
    cons_ready = 1'b0;
    rd("empty_pp_cnt", ACons, 32'd1);
    check_eq("empty_pp_data", {24'b0, cons_data}, 32'h77);
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
    check_eq("empty_pp_drained", {31'b0, cons_valid}, 32'd0);

    // Push+pop while full: count unchanged, no overflow, new entry last
    for (int k = 0; k < 8; k++) wr(ACons, 32'h61 + k);
    rd("refill_stat", AStat, 32'b001);
    cons_ready = 1'b1;
    wr(ACons, 32'h55);
    cons_ready = 1'b0;
    rd("full_pp_cnt", ACons, 32'd8);
    rd("full_pp_stat", AStat, 32'b001);
    for (int k = 0; k < 7; k++) exp_q[k] = 8'h62 + 8'(k);
    exp_q[7] = 8'h55;
    cons_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("full_pp_data", {24'b0, cons_data}, {24'b0, exp_q[k]});
      @(negedge clk);
    end
    cons_ready = 1'b0;
    check_eq("full_pp_end", {31'b0, cons_valid}, 32'd0);

`ifdef DMEM_TIMER_EN
    do_reset();
    wr(ATmrCmp, 32'd20);
    repeat (19) @(negedge clk);
    rd("tmr_cyc20", ACycle, 32'd20);
    check_eq("tmr_pre", {31'b0, timer_irq}, 32'd0);
    @(negedge clk);
    check_eq("tmr_rise", {31'b0, timer_irq}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("tmr_sticky", {31'b0, timer_irq}, 32'd1);
    rd("tmr_stat", ATmrSt, 32'd1);
    rd("tmr_cmp", ATmrCmp, 32'd20);
    wr(ATmrSt, 32'd1);
    check_eq("tmr_w1c", {31'b0, timer_irq}, 32'd0);
    rd("tmr_stat_clr", ATmrSt, 32'd0);
    do_reset();
    repeat (30) @(negedge clk);
    check_eq("tmr_cmp0", {31'b0, timer_irq}, 32'd0);
    do_reset();
    wr(ATmrCmp, 32'd3);
    for (int k = 0; k < 3; k++) wr(ACons, 32'h30 + k);
    check_eq("pre_rst_irq", {31'b0, timer_irq}, 32'd1);
`else
    wr(ATmrCmp, 32'd20);
    rd("notmr_cmp", ATmrCmp, 32'd0);
    wr(ATmrSt, 32'd1);
    rd("notmr_stat", ATmrSt, 32'd0);
    check_eq("notmr_irq", {31'b0, timer_irq}, 32'd0);
    do_reset();
    for (int k = 0; k < 3; k++) wr(ACons, 32'h30 + k);
`endif

    // Reset mid-operation
    rd("pre_rst_cnt", ACons, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", {31'b0, cons_valid}, 32'd0);
    check_eq("midrst_irq", {31'b0, timer_irq}, 32'd0);
    rd("midrst_cnt", ACons, 32'd0);
    rd("midrst_cyc", ACycle, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
